serial_to_parallel: RTL and testbench

SERIAL_TO_PARALLEL -- requirements
Module: serial_to_parallel

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_to_parallel.sv | 138 +++++++++++++
 tb/tb_serial_to_parallel.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial converters.
// S2P_PARITY_EN adds the PARITY state to the state enumeration.
package serial_pkg;

`ifdef S2P_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } s2p_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1
    } s2p_state_t;
`endif

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel word assembler with frame abort detection.
// Optional macro S2P_PARITY_EN appends one even-parity bit per frame and adds parity_err_o.
module serial_to_parallel
    import serial_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_i,
    input  logic                 enable_i,
    output logic [DATA_SIZE-1:0] parallel_o,
    output logic                 valid_o,
    output logic                 busy_o,
    output logic                 frame_err_o,
`ifdef S2P_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic [1:0]           state_o
);

    localparam int CNT_W = cnt_width(DATA_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_SIZE - 1);

    // Handshake: enable_i is a level qualifier held for the whole frame;
    // valid_o and frame_err_o are single-cycle pulses, never both at once.
    s2p_state_t           r_state;
    logic [CNT_W-1:0]     r_count;
    logic [DATA_SIZE-1:0] r_shift;
    logic [DATA_SIZE-1:0] r_parallel;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_frame_err;
`ifdef S2P_PARITY_EN
    logic                 r_parity_err;
`endif

    logic [DATA_SIZE-1:0] w_first;
    logic [DATA_SIZE-1:0] w_next;

    // w_first builds a word from bit 0 alone, so IDLE never depends on stale shift contents.
    always_comb begin
        w_first = '0;
        w_next  = '0;
        if (MSB_FIRST) begin
            w_first = {{(DATA_SIZE-1){1'b0}}, serial_i};
            w_next  = {r_shift[DATA_SIZE-2:0], serial_i};
        end else begin
            w_first = {serial_i, {(DATA_SIZE-1){1'b0}}};
            w_next  = {serial_i, r_shift[DATA_SIZE-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_shift     <= '0;
            r_parallel  <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef S2P_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable_i) begin
                        r_shift <= w_first;
                        r_count <= CNT_W'(1);
                        r_state <= ST_SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!enable_i) begin
                        r_shift     <= '0;
                        r_count     <= '0;
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_frame_err <= 1'b1;
                    end else if (r_count == LAST_CNT) begin
`ifdef S2P_PARITY_EN
                        r_shift <= w_next;
                        r_count <= '0;
                        r_state <= ST_PARITY;
`else
                        r_parallel <= w_next;
                        r_valid    <= 1'b1;
                        r_shift    <= '0;
                        r_count    <= '0;
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
`endif
                    end else begin
                        r_shift <= w_next;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
`ifdef S2P_PARITY_EN
                ST_PARITY: begin
                    r_shift <= '0;
                    r_count <= '0;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (!enable_i) begin
                        r_frame_err <= 1'b1;
                    end else begin
                        r_parallel   <= r_shift;
                        r_valid      <= 1'b1;
                        r_parity_err <= (^r_shift) ^ serial_i;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                    r_shift <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign parallel_o  = r_parallel;
    assign valid_o     = r_valid;
    assign busy_o      = r_busy;
    assign frame_err_o = r_frame_err;
    assign state_o     = r_state;
`ifdef S2P_PARITY_EN
    assign parity_err_o = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Bench for serial_to_parallel: an MSB-first and an LSB-first instance share one input stream.
// A frame-level model (bit queue -> word) predicts every output each cycle.
module tb_serial_to_parallel;

    localparam int W = 8;
`ifdef S2P_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         serial_i;
    logic         enable_i;
    logic [W-1:0] par_m, par_l;
    logic         valid_m, valid_l, busy_m, busy_l, err_m, err_l;
    logic [1:0]   st_m, st_l;
`ifdef S2P_PARITY_EN
    logic         pe_m, pe_l;
`endif

    // ---- clock ----
    always #5 clk = ~clk;

    serial_to_parallel #(.DATA_SIZE(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .serial_i(serial_i), .enable_i(enable_i),
        .parallel_o(par_m), .valid_o(valid_m), .busy_o(busy_m), .frame_err_o(err_m),
`ifdef S2P_PARITY_EN
        .parity_err_o(pe_m),
`endif
        .state_o(st_m)
    );

    serial_to_parallel #(.DATA_SIZE(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .serial_i(serial_i), .enable_i(enable_i),
        .parallel_o(par_l), .valid_o(valid_l), .busy_o(busy_l), .frame_err_o(err_l),
`ifdef S2P_PARITY_EN
        .parity_err_o(pe_l),
`endif
        .state_o(st_l)
    );

    // ---- model state ----
    int           bits[$];
    logic [W-1:0] exp_m, exp_l;
    logic         exp_valid, exp_busy, exp_err, exp_pe;
    int           n_pass = 0;
    int           n_total = 0;
    int           cyc = 0;
    int           valid_cycles[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        else
            n_pass++;
    endtask

    // Predict outputs after the coming edge from frame-level rules.
    task automatic model_step(input logic r, input logic e, input logic b);
        logic [W-1:0] wm, wl;
        if (r) begin
            bits.delete();
            exp_m = '0; exp_l = '0;
            exp_valid = 1'b0; exp_busy = 1'b0; exp_err = 1'b0; exp_pe = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (e) begin
                bits.push_back(int'(b));
                if (bits.size() == FL) begin
                    wm = '0; wl = '0;
                    for (int i = 0; i < W; i++) begin
                        wm = (wm << 1) | W'(bits[i]);
                        wl = wl | (W'(bits[i]) << i);
                    end
                    exp_m = wm;
                    exp_l = wl;
                    exp_valid = 1'b1;
                    if (FL > W) exp_pe = (^wm) ^ bits[FL-1][0];
                    bits.delete();
                end
            end else if (bits.size() > 0) begin
                exp_err = 1'b1;
                bits.delete();
            end
            exp_busy = (bits.size() > 0);
        end
    endtask

    // ---- driver: one clock per call, drive on negedge, compare on next negedge ----
    task automatic step(input logic r, input logic e, input logic b);
        rst = r; enable_i = e; serial_i = b;
        model_step(r, e, b);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (valid_m) valid_cycles.push_back(cyc);
        chk("par_msb",   par_m,   exp_m);
        chk("par_lsb",   par_l,   exp_l);
        chk("valid_msb", valid_m, exp_valid);
        chk("valid_lsb", valid_l, exp_valid);
        chk("busy",      busy_m,  exp_busy);
        chk("busy_lsb",  busy_l,  exp_busy);
        chk("frame_err", err_m,   exp_err);
        chk("frame_err_lsb", err_l, exp_err);
        chk("valid_err_excl", valid_m & err_m, 1'b0);
`ifdef S2P_PARITY_EN
        chk("parity_err", pe_m, exp_pe);
        chk("parity_err_lsb", pe_l, exp_pe);
`endif
    endtask

    task automatic send_word(input logic [W-1:0] word, input bit msb_order, input bit keep_en);
        for (int i = 0; i < W; i++)
            step(1'b0, 1'b1, msb_order ? word[W-1-i] : word[i]);
`ifdef S2P_PARITY_EN
        step(1'b0, 1'b1, ^word);
`endif
        if (!keep_en) step(1'b0, 1'b0, 1'b0);
    endtask

    logic [W-1:0] table_w [4];
    logic [W-1:0] b_w;

    initial begin
        rst = 1'b1; enable_i = 1'b0; serial_i = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("reset_par", par_m, 8'h00);
        chk("reset_busy", busy_m, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // MSB-first 1,1,0,1,0,0,1,0 -> D2; the LSB-first instance sees 0x4B
        b_w = 8'hD2;
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, b_w[W-1-i]);
`ifdef S2P_PARITY_EN
        step(1'b0, 1'b1, 1'b0);
`endif
        chk("d2_msb_word", par_m, 8'hD2);
        chk("d2_valid_latency", valid_m, 1'b1);
        chk("d2_lsb_word", par_l, 8'h4B);
        step(1'b0, 1'b0, 1'b0);
        chk("d2_valid_one_cycle", valid_m, 1'b0);
        chk("d2_hold", par_m, 8'hD2);

        // LSB-first 0,1,0,0,1,0,1,1 -> D2
        send_word(8'hD2, 1'b0, 1'b0);
        chk("lsb_d2_word", par_l, 8'hD2);
        chk("lsb_d2_msb_view", par_m, 8'h4B);

        // back-to-back D2 then 3C, no gap
        valid_cycles.delete();
        send_word(8'hD2, 1'b1, 1'b1);
        send_word(8'h3C, 1'b1, 1'b0);
        chk("b2b_pulses", valid_cycles.size(), 2);
        if (valid_cycles.size() == 2)
            chk("b2b_spacing", valid_cycles[1] - valid_cycles[0], FL);
        chk("b2b_last_word", par_m, 8'h3C);

        // abort after 5 bits
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, i[0]);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_err", err_m, 1'b1);
        chk("abort_no_valid", valid_m, 1'b0);
        chk("abort_hold", par_m, 8'h3C);
        chk("abort_busy", busy_m, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("abort_err_one_cycle", err_m, 1'b0);

        // reset mid-frame, then a clean A5 frame
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("midrst_par", par_m, 8'h00);
        chk("midrst_no_err", err_m, 1'b0);
        chk("midrst_busy", busy_m, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("midrst_no_err_after", err_m, 1'b0);
        send_word(8'hA5, 1'b1, 1'b0);
        chk("a5_word", par_m, 8'hA5);
        chk("a5_word_lsb", par_l, 8'hA5);

`ifdef S2P_PARITY_EN
        b_w = 8'hD2;
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, b_w[W-1-i]);
        step(1'b0, 1'b1, 1'b1);
        chk("parity_bad", pe_m, 1'b1);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, b_w[W-1-i]);
        step(1'b0, 1'b1, 1'b0);
        chk("parity_good", pe_m, 1'b0);
        for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("parity_abort", err_m, 1'b1);
`endif

        // streamed table with enable held across words
        table_w[0] = 8'h00; table_w[1] = 8'hFF; table_w[2] = 8'h81; table_w[3] = 8'h7E;
        valid_cycles.delete();
        for (int k = 0; k < 4; k++) send_word(table_w[k], 1'b1, k != 3);
        chk("table_pulses", valid_cycles.size(), 4);
        chk("table_last", par_m, 8'h7E);
        chk("table_last_lsb", par_l, 8'h7E);
        step(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
